// File: rtl/matrix_multiply_result_packer.sv
// Groups the 3x3 matmul core's dot-product stream into 3-element vectors,
// rescales and saturates each element, and queues vectors in a 2-deep FIFO.
module matrix_multiply_result_packer #(
    parameter int SHIFT = 4,
    parameter int OUT_W = 14,
    parameter int CNT_W = 16
) (
    input  logic                 system1000,
    input  logic                 system1000_rstn,
    input  logic [33:0]          result,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3*OUT_W-1:0]   out_data,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic [CNT_W-1:0]     sat_cnt
);

    // Rounding constant is 2^(SHIFT-1), which collapses to 0 when SHIFT == 0.
    localparam logic signed [33:0] RND   = (34'sd1 <<< SHIFT) >>> 1;
    localparam logic signed [33:0] MAX_V = (34'sd1 <<< (OUT_W - 1)) - 34'sd1;
    localparam logic signed [33:0] MIN_V = -(34'sd1 <<< (OUT_W - 1));

    logic                    in_vld;
    logic signed [33:0]      sum_ext;
    logic signed [33:0]      rounded;
    logic signed [33:0]      scaled;
    logic [OUT_W-1:0]        elem;
    logic                    clipped;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [3*OUT_W-1:0]      vec_new;

    logic [1:0]              idx;
    logic [1:0][OUT_W-1:0]   part;
    logic [1:0]              cnt;
    logic [3*OUT_W-1:0]      head;
    logic [3*OUT_W-1:0]      tail;

    assign in_vld = result[33];

    // Data bits are masked when invalid so X on an idle bus never reaches state.
    assign sum_ext = in_vld ? {result[32], result[32:0]} : '0;
    assign rounded = sum_ext + RND;
    assign scaled  = rounded >>> SHIFT;

    always_comb begin
        elem    = scaled[OUT_W-1:0];
        clipped = 1'b0;
        if (scaled > MAX_V) begin
            elem    = MAX_V[OUT_W-1:0];
            clipped = 1'b1;
        end else if (scaled < MIN_V) begin
            elem    = MIN_V[OUT_W-1:0];
            clipped = 1'b1;
        end
    end

    assign accept    = in_vld && !flush;
    assign push      = accept && (idx == 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign drop      = push && (cnt == 2'd2) && !pop;
    assign vec_new   = {elem, part[1], part[0]};
    assign out_data  = head;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            idx  <= '0;
            part <= '0;
        end else if (flush) begin
            idx  <= '0;
            part <= '0;
        end else if (accept) begin
            if (idx == 2'd2) begin
                idx <= '0;
            end else begin
                part[idx[0]] <= elem;
                idx          <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            sat_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (accept && clipped && (sat_cnt != '1))
                sat_cnt <= sat_cnt + 1'b1;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // Head is always the registered output; tail only matters when cnt == 2.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else if (push && pop) begin
            if (cnt == 2'd2) begin
                head <= tail;
                tail <= vec_new;
            end else begin
                head <= vec_new;
            end
        end else if (pop) begin
            if (cnt == 2'd2)
                head <= tail;
            cnt <= cnt - 2'd1;
        end else if (push) begin
            if (cnt == 2'd0) begin
                head <= vec_new;
                cnt  <= 2'd1;
            end else if (cnt == 2'd1) begin
                tail <= vec_new;
                cnt  <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_matrix_multiply_result_packer.sv
// Directed bench for matrix_multiply_result_packer with SHIFT=4, OUT_W=14.
module tb_matrix_multiply_result_packer;

    localparam int OUT_W = 14;
    localparam int CNT_W = 16;

    logic               system1000;
    logic               system1000_rstn;
    logic [33:0]        result;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [3*OUT_W-1:0] out_data;
    logic               ovf;
    logic               ovf_clr;
    logic [CNT_W-1:0]   sat_cnt;

    int n_checks;
    int n_fail;

    matrix_multiply_result_packer #(.SHIFT(4), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .result          (result),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .ovf             (ovf),
        .ovf_clr         (ovf_clr),
        .sat_cnt         (sat_cnt)
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    function automatic logic [3*OUT_W-1:0] pack3(input int e2, input int e1, input int e0);
        return {14'(e2), 14'(e1), 14'(e0)};
    endfunction

    // One valid result for one cycle; returns 1 time unit after the capturing edge.
    task automatic send(input int v);
        result = {1'b1, 33'(v)};
        @(posedge system1000);
        #1;
        result = {1'b0, 33'h0};
    endtask

    task automatic tick();
        @(posedge system1000);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_checks++;
        if (sat_cnt !== '0) begin n_fail++; $display("FAIL reset_sat got %0d want 0", sat_cnt); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(160);
        send(-24);
        send(0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== pack3(0, -1, 10)) begin n_fail++; $display("FAIL basic_data got %h want %h", out_data, pack3(0, -1, 10)); end
        n_checks++;
        if (sat_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_sat got %0d want 0", sat_cnt); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped got %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        send(200000);
        send(-200000);
        send(8191 * 16);
        n_checks++;
        if (out_data !== pack3(8191, -8192, 8191)) begin n_fail++; $display("FAIL sat_data got %h want %h", out_data, pack3(8191, -8192, 8191)); end
        n_checks++;
        if (sat_cnt !== 16'd2) begin n_fail++; $display("FAIL sat_cnt got %0d want 2", sat_cnt); end
        tick();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            send(16 * v);
            send(32 * v);
            send(48 * v);
        end
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf); end
        n_checks++;
        if (out_data !== pack3(3, 2, 1)) begin n_fail++; $display("FAIL ovf_head1 got %h want %h", out_data, pack3(3, 2, 1)); end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== pack3(6, 4, 2)) begin n_fail++; $display("FAIL ovf_head2 got %b/%h want 1/%h", out_valid, out_data, pack3(6, 4, 2)); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== pack3(6, 4, 2)) begin n_fail++; $display("FAIL ovf_hold got %h want %h", out_data, pack3(6, 4, 2)); end
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", ovf); end
    endtask

    task automatic test_ovf_set_wins();
        out_ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            send(16);
            send(32);
            if (v == 3) ovf_clr = 1'b1;
            send(48);
            ovf_clr = 1'b0;
        end
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b want 1", ovf); end
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        tick();
        tick();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL set_wins_drain got %b/%b want 0/0", ovf, out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int v = 1; v <= 2; v++) begin
            send(16 * v);
            send(32 * v);
            send(48 * v);
        end
        n_checks++;
        if (out_data !== pack3(3, 2, 1)) begin n_fail++; $display("FAIL b2b_head1 got %h want %h", out_data, pack3(3, 2, 1)); end
        send(48);
        send(96);
        out_ready = 1'b1;
        send(144);
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_no_ovf got %b want 0", ovf); end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== pack3(6, 4, 2)) begin n_fail++; $display("FAIL b2b_v2 got %b/%h want 1/%h", out_valid, out_data, pack3(6, 4, 2)); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== pack3(9, 6, 3)) begin n_fail++; $display("FAIL b2b_v3 got %b/%h want 1/%h", out_valid, out_data, pack3(9, 6, 3)); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(160);
        send(320);
        flush = 1'b1;
        send(999 * 16);
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got %b want 0", out_valid); end
        send(16);
        send(32);
        send(48);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== pack3(3, 2, 1)) begin n_fail++; $display("FAIL flush_vec got %b/%h want 1/%h", out_valid, out_data, pack3(3, 2, 1)); end
        n_checks++;
        if (sat_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_sat got %0d want 2", sat_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(16);
        system1000_rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || ovf !== 1'b0 || sat_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_async got v=%b d=%h o=%b s=%0d want all 0", out_valid, out_data, ovf, sat_cnt);
        end
        system1000_rstn = 1'b1;
        send(16);
        send(32);
        send(48);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== pack3(3, 2, 1)) begin n_fail++; $display("FAIL rst_align got %b/%h want 1/%h", out_valid, out_data, pack3(3, 2, 1)); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        system1000_rstn = 1'b0;
        result = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(posedge system1000);
        #1;
        test_reset();
        system1000_rstn = 1'b1;
        tick();
        test_basic();
        test_saturation();
        test_overflow();
        test_ovf_set_wins();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
